// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a common 7-segment display. One digit
// position is lit at a time for SCAN_DIV clock cycles (a "slot"); the first
// cycle of every slot is kept dark so the previous digit's segment pattern
// cannot ghost onto the newly enabled digit.
//
// New display values arrive through a one-deep valid/ready buffer (Pending)
// and are only copied into the displayed register (Shadow) at the frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Parameters
//   NUM_DIGITS  number of multiplexed digit positions (2..8)
//   SCAN_DIV    clock cycles per digit slot (>= 2)
//
// Ports
//   Clk        in   single clock, rising edge
//   ResetN     in   asynchronous active-low reset
//   LoadValid  in   a new display value is offered on LoadData
//   LoadReady  out  the buffer can accept LoadData this cycle
//   LoadData   in   packed nibbles, digit i at bits 4i+3:4i (top digit = MSD)
//   BlankMask  in   bit i forces digit i dark (sampled live)
//   Nibble     out  hex value of the digit currently being scanned
//   DigitEn    out  one-hot digit enable, all-zero = dark
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits of the displayed
//                          value are suppressed (digit 0 always shows).
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  input  logic                    LoadValid,
  output logic                    LoadReady,
  input  logic [4*NUM_DIGITS-1:0] LoadData,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  output logic [3:0]              Nibble,
  output logic [NUM_DIGITS-1:0]   DigitEn
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int PTR_W  = $clog2(NUM_DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic              full;
    logic [DATA_W-1:0] data;
  } pending_t;

  logic [DIV_W-1:0]      div;
  logic [PTR_W-1:0]      ptr;
  pending_t              pending;
  logic [DATA_W-1:0]     shadow;

  logic                  slot_end;
  logic                  frame_end;
  logic                  load_fire;
  logic                  ptr_blank;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign slot_end  = (div == DIV_LAST);
  assign frame_end = slot_end && (ptr == PTR_LAST);
  assign LoadReady = ~pending.full;
  assign load_fire = LoadValid && LoadReady;

  // -------------------------------------------------------------------------
  // Scan position: Div counts cycles within a slot, Ptr selects the digit.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      div <= '0;
      ptr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (slot_end) begin
        div <= '0;
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending / Shadow double buffer.
  // The copy happens only when full, and a capture only when not full, so a
  // value captured on the frame-boundary edge cannot reach Shadow until the
  // following boundary.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      // NOTE: the data registers are reset too (not just the flag): a reset
      // must blank the display and drop any stale value, so these are
      // ordinary flops, not a RAM that could be left uninitialised.
      pending <= '0;
      shadow  <= '0;
    end else if (frame_end && pending.full) begin
      shadow       <= pending.data;
      pending.full <= 1'b0;
    end else if (load_fire) begin
      pending.data <= LoadData;
      pending.full <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero suppression: digit i (i > 0) is dark when it and every
  // more-significant digit of Shadow are zero.
  // -------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (shadow[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // -------------------------------------------------------------------------
  // Output decode from registered state (plus the live BlankMask).
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    Nibble    = '0;
    ptr_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ptr == PTR_W'(i)) begin
        Nibble    = shadow[4*i +: 4];
        ptr_blank = BlankMask[i] || lz_blank[i];
      end
    end
  end

  // Div == 0 is the anti-ghosting dark cycle at the start of each slot.
  always_comb begin
    DigitEn = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      DigitEn[i] = (ptr == PTR_W'(i)) && (div != '0) && !ptr_blank;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4 (16-cycle frame).
// The reference model tracks elapsed cycles since reset and derives the scan
// position arithmetically (slot = t / SCAN_DIV), holding Pending/Shadow as
// plain variables. A vector table covers the first load after reset; the
// remaining corner cases are hand-written sequences followed by random
// traffic. Works with LEADING_ZERO_BLANK_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int FRAME = ND * SD;

  logic        Clk       = 1'b0;
  logic        ResetN    = 1'b0;
  logic        LoadValid = 1'b0;
  logic [15:0] LoadData  = '0;
  logic [3:0]  BlankMask = '0;
  logic        LoadReady;
  logic [3:0]  Nibble;
  logic [3:0]  DigitEn;

  always #5 Clk = ~Clk;

  display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .LoadValid (LoadValid),
    .LoadReady (LoadReady),
    .LoadData  (LoadData),
    .BlankMask (BlankMask),
    .Nibble    (Nibble),
    .DigitEn   (DigitEn)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_t      = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend   = '0;
  bit          m_full   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (t=%0d): got %0h, want %0h", name, m_t, act, exp);
    end
  endtask

  function automatic int cur_ptr();
    return (m_t / SD) % ND;
  endfunction

  function automatic int cur_div();
    return m_t % SD;
  endfunction

  function automatic logic [3:0] exp_nib();
    logic [15:0] s;
    s = m_shadow >> (4 * cur_ptr());
    return s[3:0];
  endfunction

  function automatic logic [3:0] exp_en();
    int p;
    bit dark;
    p    = cur_ptr();
    dark = (cur_div() == 0) || BlankMask[p];
`ifdef LEADING_ZERO_BLANK_EN
    if (p > 0 && (m_shadow >> (4 * p)) == 16'h0) dark = 1'b1;
`endif
    return dark ? 4'b0000 : 4'(1 << p);
  endfunction

  function automatic void model_edge();
    bit boundary;
    boundary = (cur_div() == SD - 1) && (cur_ptr() == ND - 1);
    if (boundary && m_full) begin
      m_shadow = m_pend;
      m_full   = 1'b0;
    end else if (LoadValid && !m_full) begin
      m_pend = LoadData;
      m_full = 1'b1;
    end
    m_t++;
  endfunction

  function automatic void model_reset();
    m_t      = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_full   = 1'b0;
  endfunction

  // Called just after a falling edge: drive inputs, let them settle.
  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] m);
    LoadValid = v;
    LoadData  = d;
    BlankMask = m;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ready"},  LoadReady, !m_full);
    check({tag, "_nibble"}, Nibble,    exp_nib());
    check({tag, "_digiten"}, DigitEn,  exp_en());
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  // Asynchronous reset asserted away from both clock edges, released on a
  // falling edge so the first scan cycle after release is t=0.
  task automatic do_reset(input string tag);
    LoadValid = 1'b0;
    #2 ResetN = 1'b0;
    #1;
    check({tag, "_rst_ready"},   LoadReady, 1'b1);
    check({tag, "_rst_nibble"},  Nibble,    4'h0);
    check({tag, "_rst_digiten"}, DigitEn,   4'b0000);
    model_reset();
    @(negedge Clk);
    ResetN = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [3:0]  m;
    logic        rdy;
    logic [3:0]  nib;
    logic [3:0]  en;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // -- first load after reset: 0x1234, digits 1..3 masked during frame 0 --
    tbl[0] = '{1'b1, 16'h1234, 4'b1110, 1'b1, 4'h0, 4'b0000};
    for (int i = 1; i < 16; i++)
      tbl[i] = '{1'b0, 16'h1234, 4'b1110, 1'b0, 4'h0, (i < 4) ? 4'b0001 : 4'b0000};
    tbl[16] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h4, 4'b0000};
    tbl[17] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h4, 4'b0001};
    tbl[18] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h4, 4'b0001};
    tbl[19] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h4, 4'b0001};
    tbl[20] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h3, 4'b0000};
    tbl[21] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h3, 4'b0010};
    tbl[22] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h3, 4'b0010};
    tbl[23] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h3, 4'b0010};

    // reset state while held in reset
    #3;
    check("init_ready",   LoadReady, 1'b1);
    check("init_nibble",  Nibble,    4'h0);
    check("init_digiten", DigitEn,   4'b0000);
    @(negedge Clk);
    ResetN = 1'b1;
    model_reset();

    // -- table: load 0x1234, wait for the frame boundary, scan digits 0,1 --
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].m);
      check($sformatf("vec%0d_ready", i),   LoadReady, tbl[i].rdy);
      check($sformatf("vec%0d_nibble", i),  Nibble,    tbl[i].nib);
      check($sformatf("vec%0d_digiten", i), DigitEn,   tbl[i].en);
      tick();
    end

    // -- back-to-back loads 0xAAAA then 0x5555 with LoadValid held --
    while (m_t < 50) begin
      drive(m_t <= 47, (m_t == 24) ? 16'hAAAA : 16'h5555, 4'b0000);
      check_model("b2b");
      if (m_t == 31) check("b2b_full_at_boundary", LoadReady, 1'b0);
      if (m_t == 32) check("b2b_ready_after_boundary", LoadReady, 1'b1);
      if (m_t == 33) check("b2b_shows_aaaa", Nibble, 4'hA);
      if (m_t == 47) check("b2b_aaaa_whole_frame", Nibble, 4'hA);
      if (m_t == 49) check("b2b_shows_5555", Nibble, 4'h5);
      tick();
    end

    // -- BlankMask=0010 over Shadow=0x1234, then reset with full=1 mid-frame --
    do_reset("blank");
    while (m_t < 42) begin
      drive(m_t == 0 || m_t == 32, (m_t == 0) ? 16'h1234 : 16'hBEEF,
            (m_t >= 16 && m_t < 32) ? 4'b0010 : 4'b0000);
      check_model("blank");
      if (m_t >= 20 && m_t < 24) begin
        check("blank_digit1_dark", DigitEn, 4'b0000);
        check("blank_digit1_nib",  Nibble,  4'h3);
      end
      tick();
    end
    // now Ptr=2, Div=2, full=1 with 0xBEEF pending
    check("prerst_full", LoadReady, 1'b0);
    do_reset("midframe");
    while (m_t < 24) begin
      drive(1'b0, 16'h0000, 4'b0000);
      check_model("postrst");
      if (m_t == 1) begin
        check("postrst_ready", LoadReady, 1'b1);
        check("postrst_nib0",  Nibble,    4'h0);
        check("postrst_en0",   DigitEn,   4'b0001);
      end
      if (m_t == 17) check("postrst_no_stale_d0", Nibble, 4'h0);
      if (m_t == 21) check("postrst_no_stale_d1", Nibble, 4'h0);
      tick();
    end

    // -- leading-zero handling: 0x0050 then 0x0000 --
    do_reset("lzb");
    while (m_t < 48) begin
      drive(m_t == 0 || m_t == 16, (m_t == 0) ? 16'h0050 : 16'h0000, 4'b0000);
      check_model("lzb");
      if (m_t == 17) begin
        check("lzb50_d0_nib", Nibble, 4'h0);
        check("lzb50_d0_en",  DigitEn, 4'b0001);
      end
      if (m_t == 21) begin
        check("lzb50_d1_nib", Nibble, 4'h5);
        check("lzb50_d1_en",  DigitEn, 4'b0010);
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (m_t == 25) check("lzb50_d2_en", DigitEn, 4'b0000);
      if (m_t == 29) check("lzb50_d3_en", DigitEn, 4'b0000);
      if (m_t == 37) check("lzb00_d1_en", DigitEn, 4'b0000);
`else
      if (m_t == 25) check("lzb50_d2_en", DigitEn, 4'b0100);
      if (m_t == 29) check("lzb50_d3_en", DigitEn, 4'b1000);
      if (m_t == 37) check("lzb00_d1_en", DigitEn, 4'b0010);
`endif
      if (m_t == 33) check("lzb00_d0_en", DigitEn, 4'b0001);
      tick();
    end

    // -- accept on the frame-boundary edge with full=0 waits one more frame --
    while (m_t < 83) begin
      drive(m_t == 63, 16'h9876, 4'b0000);
      check_model("bnd");
      if (m_t == 65) begin
        check("bnd_shadow_kept", Nibble, 4'h0);
        check("bnd_pending_full", LoadReady, 1'b0);
      end
      if (m_t == 81) check("bnd_shadow_next_frame", Nibble, 4'h6);
      tick();
    end

    // -- random traffic against the model --
    for (int c = 0; c < 1200; c++) begin
      logic [15:0] d;
      logic [3:0]  m;
      if ($urandom_range(0, 299) == 0) do_reset("rnd");
      d = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      drive($urandom_range(0, 3) == 0, d, m);
      check_model("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
